// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time-setting controller and its key front end.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEditHour,
        StEditMin,
        StEditSec
    } state_e;

    typedef enum logic [2:0] {
        ActNone,
        ActMode,
        ActUp,
        ActDown,
        ActConfirm,
        ActCancel
    } action_e;

    localparam int unsigned NUM_KEYS    = 5;
    localparam int unsigned KEY_MODE    = 0;
    localparam int unsigned KEY_UP      = 1;
    localparam int unsigned KEY_DOWN    = 2;
    localparam int unsigned KEY_CONFIRM = 3;
    localparam int unsigned KEY_CANCEL  = 4;

    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINSEC_MAX = 8'd59;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    // Simultaneous presses collapse to a single action: cancel > confirm > mode > up > down.
    function automatic action_e pick_action(input logic [NUM_KEYS-1:0] p);
        if (p[KEY_CANCEL])       return ActCancel;
        else if (p[KEY_CONFIRM]) return ActConfirm;
        else if (p[KEY_MODE])    return ActMode;
        else if (p[KEY_UP])      return ActUp;
        else if (p[KEY_DOWN])    return ActDown;
        else                     return ActNone;
    endfunction

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max);
        return (v == 8'd0 || v > max) ? max : v - 8'd1;
    endfunction

    function automatic logic [1:0] field_of(input state_e s);
        case (s)
            StEditHour: return FIELD_HOUR;
            StEditMin:  return FIELD_MIN;
            StEditSec:  return FIELD_SEC;
            default:    return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_key_debounce.sv
// Single-key front end: 2-flop synchronizer, consecutive-mismatch debounce filter and
// registered rising-edge press pulse.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Accept on the DEB_CYCLES-th consecutive mismatch; any agreement clears the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Push-button time editor: debounces five keys, edits a copy of the running time field by
// field and hands it back to the timekeeping stage with a one-cycle load pulse.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 1000000,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic       load,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BlinkMax = BW'(BLINK_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] unused_key_level;
    action_e             act;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_key_debounce (
            .clk   (clk),
            .rst   (rst),
            .din   (key[i]),
            .level (unused_key_level[i]),
            .press (key_press[i])
        );
    end

    state_e        state_q, state_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          load_q, load_d;
    logic          editing_q, editing_d;
    logic [1:0]    field_sel_q, field_sel_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_restart;

    assign act = pick_action(key_press);

    always_comb begin
        state_d       = state_q;
        hour_d        = hour_q;
        min_d         = min_q;
        sec_d         = sec_q;
        load_d        = 1'b0;
        blink_restart = 1'b0;

        if (state_q == StIdle) begin
            if (act == ActMode) begin
                hour_d        = cur_hour;
                min_d         = cur_min;
                sec_d         = cur_sec;
                state_d       = StEditHour;
                blink_restart = 1'b1;
            end
        end else begin
            case (act)
                ActMode: begin
                    case (state_q)
                        StEditHour: state_d = StEditMin;
                        StEditMin:  state_d = StEditSec;
                        default:    state_d = StEditHour;
                    endcase
                    blink_restart = 1'b1;
                end
                ActUp, ActDown: begin
                    case (state_q)
                        StEditHour: hour_d = (act == ActUp) ? wrap_inc(hour_q, HOUR_MAX)
                                                            : wrap_dec(hour_q, HOUR_MAX);
                        StEditMin:  min_d  = (act == ActUp) ? wrap_inc(min_q, MINSEC_MAX)
                                                            : wrap_dec(min_q, MINSEC_MAX);
                        default:    sec_d  = (act == ActUp) ? wrap_inc(sec_q, MINSEC_MAX)
                                                            : wrap_dec(sec_q, MINSEC_MAX);
                    endcase
                    blink_restart = 1'b1;
                end
                ActConfirm: begin
                    load_d  = 1'b1;
                    state_d = StIdle;
                end
                ActCancel: state_d = StIdle;
                default: ;
            endcase
        end

        editing_d   = (state_d != StIdle);
        field_sel_d = field_of(state_d);

        // Blink phase restarts high on every visible edit so the field is never blanked
        // right after the user touches it.
        if (state_d == StIdle) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (blink_restart) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BlinkMax) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            hour_q      <= 8'd0;
            min_q       <= 8'd0;
            sec_q       <= 8'd0;
            load_q      <= 1'b0;
            editing_q   <= 1'b0;
            field_sel_q <= FIELD_NONE;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            load_q      <= load_d;
            editing_q   <= editing_d;
            field_sel_q <= field_sel_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign set_hour  = hour_q;
    assign set_min   = min_q;
    assign set_sec   = sec_q;
    assign load      = load_q;
    assign editing   = editing_q;
    assign field_sel = field_sel_q;
    assign blink     = blink_q;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, number of consecutive stable clk cycles before a key level is accepted (10 ms at 100 MHz).
REQ-002 Parameter BLINK_CYCLES, default 25000000, clk cycles per half-period of the blink flag (2 Hz toggle).
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 key  input  5  raw push-buttons, active-high, asynchronous: [0]=mode, [1]=up, [2]=down, [3]=confirm, [4]=cancel.
REQ-006 cur_hour, cur_min, cur_sec  input  8 each  running time from the timekeeping stage, binary, 0..23 / 0..59 / 0..59.
REQ-007 set_hour, set_min, set_sec  output  8 each  edited time value, binary.
REQ-008 load  output  1  one-cycle pulse; timekeeping stage copies set_* when high.
REQ-009 editing  output  1  high while in any EDIT state; display stage shows set_* instead of cur_*.
REQ-010 field_sel  output  2  0=none, 1=hour, 2=min, 3=sec; field under edit.
REQ-011 blink  output  1  toggling flag for blanking the selected field; 0 when not editing.

Function
REQ-012 Each key shall pass a 2-flop synchronizer, then a filter whose debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-013 A press pulse shall be asserted for exactly one cycle on each 0->1 transition of a debounced level; releases generate nothing; a held key generates one pulse only.
REQ-014 When several press pulses occur in the same cycle, only the highest priority acts: cancel > confirm > mode > up > down; the rest are discarded.
REQ-015 FSM states IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC; outputs and state update on the clk edge following the press pulse (1-cycle latency pulse->effect).
REQ-016 IDLE + mode: snapshot cur_* into set_*, go EDIT_HOUR; up/down/confirm/cancel in IDLE ignored.
REQ-017 EDIT_x + mode: advance HOUR->MIN->SEC->HOUR; set_* unchanged.
REQ-018 EDIT_x + up: selected field +1, wrapping hour 23->0, min/sec 59->0; down: -1, wrapping hour 0->23, min/sec 0->59; other fields unchanged, no carry.
REQ-019 EDIT_x + confirm: load=1 for one cycle with set_* holding the edited values, go IDLE.
REQ-020 EDIT_x + cancel: go IDLE, load stays 0, set_* retain last values.
REQ-021 In IDLE set_* shall hold their value; load shall never be asserted outside REQ-019.
REQ-022 field_sel and editing shall be registered decodes of the state (IDLE->0/0).
REQ-023 blink counter runs only while editing; it restarts at 0 with blink=1 on entry to any EDIT state and on every up/down/mode action, toggling every BLINK_CYCLES cycles.

Reset
REQ-024 rst=0 at a clk edge shall force: state IDLE, set_*=0, load=0, editing=0, field_sel=0, blink=0, debounced levels=0, filter and blink counters=0, synchronizers=0.
REQ-025 Reset during an EDIT state shall abandon the edit with no load pulse; a key held through reset release shall produce one press after DEB_CYCLES.

Structure
REQ-026 Shared package shall hold the state enum, key index constants (KEY_MODE..KEY_CANCEL), HOUR_MAX=23, MINSEC_MAX=59, and field_sel codes.
REQ-027 Debounce+edge detect shall be a sub-module key_debounce (parameter DEB_CYCLES, ports clk, rst, din, level, press), instantiated five times.

Verification (bench uses DEB_CYCLES=4, BLINK_CYCLES=8)
REQ-028 Bounce key[1] 1-0-1 with 2-cycle gaps, then hold 10 cycles -> exactly one up pulse, none during bounce.
REQ-029 cur=12:34:56, press mode -> editing=1, field_sel=1, set=12:34:56; up x12 -> set_hour=0; down -> 23.
REQ-030 From EDIT_HOUR, mode x2 -> field_sel=3; set_sec=59, up -> 0, set_min unchanged; confirm -> load high exactly one cycle with set=23:34:00, then IDLE.
REQ-031 mode+up+down pressed same cycle in EDIT_MIN -> field_sel=3, set_min unchanged; cancel+confirm same cycle -> IDLE, no load.
REQ-032 rst=0 asserted mid-edit -> all outputs 0 next edge, no load; held key across reset release -> one press after 4+2 cycles.
